adc_spi_frame_capture: RTL and testbench
========================================

// Module: adc_spi_frame_capture
// PURPOSE
//  Parametrised successor to the AD7352 capture FSM. Drives one shared SCLK/CS_n to N_CH serial ADC data
//  lines, deserialises DATA_W-bit MSB-first words after LEAD_ZEROS leading bits, and emits one AXI-Stream
//  beat per conversion with all channels packed. Adds free-running auto-trigger, backpressure overrun count.
// PARAMETERS
//  N_CH        6   number of serial data lines (1..16)
//  DATA_W      12  conversion bits per channel (1..16)
//  LEAD_ZEROS  2   leading bits clocked before the MSB and discarded (0..7)
//  SCLK_HALF   2   clk cycles per SCLK half-period (>=1)
//  CS_SETUP    2   clk cycles CS_n low, SCLK high, before first SCLK falling edge (>=1)
//  QUIET       2   clk cycles CS_n high after a frame before next frame may start (>=1)
//  PERIOD_W    16  width of auto_period
// PORTS
//  clk            in   1          system clock
//  rst_n          in   1          async active-low reset
//  start_cnv      in   1          async trigger; 2-FF synchronised, rising edge starts a frame
//  auto_en        in   1          1 = self-trigger every auto_period clks (start_cnv ignored)
//  auto_period    in   PERIOD_W   auto-trigger period in clks; 0 = auto trigger disabled
//  adc_sclk       out  1          serial clock, idles high
//  adc_cs_n       out  1          chip select, active low
//  adc_sdata      in   N_CH       serial data, bit i = channel i
//  m_axis_tdata   out  N_CH*16    lane i = bits [16i+15:16i] = {zero pad, channel i word}
//  m_axis_tvalid  out  1
//  m_axis_tready  in   1
//  m_axis_tlast   out  1          constant 1 (one beat per frame)
//  busy           out  1          1 while FSM is not IDLE
//  overrun_cnt    out  8          saturating count of frames dropped due to backpressure
// BEHAVIOUR
//  Reset (async, rst_n=0): adc_sclk=1, adc_cs_n=1, tvalid=0, tdata=0, busy=0, overrun_cnt=0, FSM=IDLE,
//   sync FFs and period counter cleared. Reset mid-frame aborts immediately; no partial beat is emitted.
//  FSM: IDLE -> CS_SETUP -> (SCLK_LO <-> SCLK_HI) x FRAME_BITS -> QUIET -> IDLE; FRAME_BITS=LEAD_ZEROS+DATA_W.
//  IDLE: trigger = synced rising edge of start_cnv (auto_en=0) or period tick (auto_en=1); next cycle
//   CS_SETUP with cs_n=0, sclk=1, held CS_SETUP cycles.
//  SCLK_LO: sclk=0 for SCLK_HALF cycles. SCLK_HI: sclk=1 for SCLK_HALF cycles; adc_sdata sampled on the
//   last clk of each high phase. Bits with index < LEAD_ZEROS discarded; remaining shifted in MSB first.
//  After final SCLK_HI: cs_n=1, sclk stays 1, QUIET cycles, then IDLE. Frame length from trigger cycle to
//   IDLE = 1 + CS_SETUP + 2*SCLK_HALF*FRAME_BITS + QUIET clks (defaults: 1+2+56+2 = 61).
//  Triggers while busy are ignored (no queueing). Period counter free-runs 0..auto_period-1 while auto_en=1
//   and auto_period!=0; tick at wrap; cleared when auto_en=0. auto_period shorter than a frame -> frames
//   back-to-back separated by QUIET.
//  Output: on entry to QUIET, if tvalid=0 or (tvalid & tready) this cycle, load tdata and set tvalid=1.
//   Else (tvalid=1, tready=0) the new frame is dropped, held beat unchanged, overrun_cnt+=1, saturate 255.
//  tvalid clears on tvalid&tready unless a new beat loads same cycle. tdata stable while tvalid&!tready.
// CONFIGURATION
//  ADC_SPI_TSTAMP_EN defined: adds output m_axis_tuser[31:0] = free-running 32-bit clk counter (reset 0,
//   wraps) captured on the cycle cs_n falls; held/dropped with tdata. Undefined: port and counter absent.
// STRUCTURE
//  Shared package adc_spi_pkg: LANE_W=16 constant, FSM state enum (IDLE, CS_SETUP, SCLK_LO, SCLK_HI, QUIET),
//   function lane_pack(). One sub-module adc_spi_trig: 2-FF sync, edge detect, period counter -> 1-cycle
//   trigger pulse. Serialiser FSM, shift regs, output register stay in the top.
// TESTING
//  1 Defaults; start_cnv pulse; ADC model drives 2 zeros + 0xA5C on ch0, 0x123 on ch5 -> one beat,
//    lane0=0x0A5C, lane5=0x0123, tlast=1; exactly 14 sclk falling edges; cs_n low 58 clks.
//  2 auto_en=1, auto_period=100, tready=1 -> frames start exactly every 100 clks; 10 beats in 1000 clks.
//  3 auto_period=20 (< frame length) -> back-to-back frames, cs_n high exactly QUIET=2 clks between.
//  4 tready=0 for 3 frames -> first beat held unchanged, overrun_cnt=2; tready=1 -> beat accepted, tvalid=0.
//  5 rst_n low at bit 7 of a frame -> same cycle sclk=1, cs_n=1, tvalid=0; no beat after release.
//  6 start_cnv pulsed during busy -> ignored, one beat only; ADC_SPI_TSTAMP_EN: tuser = clk count at cs_n fall.

Source files
------------

// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg: shared lane width, capture FSM state type and lane packing helper.
package adc_spi_pkg;
    localparam int LANE_W = 16;
    typedef enum logic [2:0] {IDLE, CS_SETUP, SCLK_LO, SCLK_HI, QUIET} state_t;
    function automatic logic [LANE_W-1:0] lane_pack(input logic [LANE_W-1:0] word, input int width);
        return word & ((LANE_W'(1) << width) - LANE_W'(1));
    endfunction
endpackage

// File: rtl/adc_spi_trig.sv
// adc_spi_trig: start_cnv 2-FF sync with rising-edge detect, or free-running auto period tick.
module adc_spi_trig #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_cnv,
    input  logic                auto_en,
    input  logic [PERIOD_W-1:0] auto_period,
    output logic                trig
);
    logic [2:0] r_sync;
    logic [PERIOD_W-1:0] r_cnt;
    logic w_run, w_tick;
    assign w_run  = auto_en && auto_period != '0;
    assign w_tick = w_run && r_cnt >= auto_period - 1'b1;
    assign trig   = auto_en ? w_tick : r_sync[1] & ~r_sync[2];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_sync <= '0;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[1:0], start_cnv};
            r_cnt  <= (!w_run || w_tick) ? '0 : r_cnt + 1'b1;
        end
endmodule

// File: rtl/adc_spi_frame_capture.sv
// adc_spi_frame_capture: N_CH-lane serial ADC frame capture to one AXI-Stream beat per conversion.
// Define ADC_SPI_TSTAMP_EN to add m_axis_tuser carrying the clk count at the cs_n falling edge.
module adc_spi_frame_capture
    import adc_spi_pkg::*;
#(
    parameter int N_CH       = 6,
    parameter int DATA_W     = 12,
    parameter int LEAD_ZEROS = 2,
    parameter int SCLK_HALF  = 2,
    parameter int CS_SETUP   = 2,
    parameter int QUIET      = 2,
    parameter int PERIOD_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_cnv,
    input  logic                   auto_en,
    input  logic [PERIOD_W-1:0]    auto_period,
    output logic                   adc_sclk,
    output logic                   adc_cs_n,
    input  logic [N_CH-1:0]        adc_sdata,
    output logic [N_CH*LANE_W-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
`ifdef ADC_SPI_TSTAMP_EN
    output logic [31:0]            m_axis_tuser,
`endif
    output logic                   busy,
    output logic [7:0]             overrun_cnt
);
    localparam int FRAME_BITS = LEAD_ZEROS + DATA_W;
    state_t r_state, w_state_nxt;
    logic [15:0] r_cnt, w_len;
    logic [4:0] r_bit;
    logic [DATA_W-1:0] r_sh [N_CH];
    logic [N_CH*LANE_W-1:0] w_pack;
    logic w_trig, w_done, w_sample, w_enter_q, w_load, w_start, w_chain, r_due;

    adc_spi_trig #(.PERIOD_W(PERIOD_W)) u_trig (
        .clk(clk), .rst_n(rst_n), .start_cnv(start_cnv),
        .auto_en(auto_en), .auto_period(auto_period), .trig(w_trig)
    );

    assign w_len = r_state == adc_spi_pkg::CS_SETUP ? 16'(CS_SETUP) :
                   r_state == adc_spi_pkg::QUIET    ? 16'(QUIET) : 16'(SCLK_HALF);
    assign w_done    = r_cnt == w_len - 16'd1;
    assign w_sample  = r_state == SCLK_HI && w_done;
    assign w_enter_q = w_sample && r_bit == 5'(FRAME_BITS - 1);
    assign w_load    = w_enter_q && (!m_axis_tvalid || m_axis_tready);
    assign w_start   = w_state_nxt == adc_spi_pkg::CS_SETUP && r_state != adc_spi_pkg::CS_SETUP;
    // An auto period that elapsed mid-frame chains the next frame straight after QUIET.
    assign w_chain   = r_due || (auto_en && w_trig);
    assign busy         = r_state != IDLE;
    assign adc_sclk     = r_state != SCLK_LO;
    assign adc_cs_n     = !(r_state == adc_spi_pkg::CS_SETUP || r_state == SCLK_LO || r_state == SCLK_HI);
    assign m_axis_tlast = 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:                 if (w_trig) w_state_nxt = adc_spi_pkg::CS_SETUP;
            adc_spi_pkg::CS_SETUP: if (w_done) w_state_nxt = SCLK_LO;
            SCLK_LO:              if (w_done) w_state_nxt = SCLK_HI;
            SCLK_HI:              if (w_done) w_state_nxt = w_enter_q ? adc_spi_pkg::QUIET : SCLK_LO;
            adc_spi_pkg::QUIET:    if (w_done) w_state_nxt = w_chain ? adc_spi_pkg::CS_SETUP : IDLE;
            default:              w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_due   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (w_state_nxt != r_state || r_state == IDLE) ? '0 : r_cnt + 16'd1;
            r_bit   <= r_state == adc_spi_pkg::CS_SETUP ? '0 : w_sample ? r_bit + 5'd1 : r_bit;
            r_due   <= auto_en && busy && !w_start && (r_due || w_trig);
        end

    // Leading bits simply fall off the top of the DATA_W-bit shift register.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) for (int c = 0; c < N_CH; c++) r_sh[c] <= '0;
        else if (w_sample) for (int c = 0; c < N_CH; c++) r_sh[c] <= DATA_W'({r_sh[c], adc_sdata[c]});

    for (genvar c = 0; c < N_CH; c++) begin : g_lane
        assign w_pack[c*LANE_W +: LANE_W] = lane_pack(LANE_W'({r_sh[c], adc_sdata[c]}), DATA_W);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            overrun_cnt   <= '0;
        end else if (w_load) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= w_pack;
        end else begin
            if (m_axis_tready) m_axis_tvalid <= 1'b0;
            if (w_enter_q && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
        end

`ifdef ADC_SPI_TSTAMP_EN
    logic [31:0] r_clk_cnt, r_ts;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_clk_cnt    <= '0;
            r_ts         <= '0;
            m_axis_tuser <= '0;
        end else begin
            r_clk_cnt <= r_clk_cnt + 32'd1;
            if (w_start) r_ts <= r_clk_cnt + 32'd1;
            if (w_load) m_axis_tuser <= r_ts;
        end
`endif
endmodule

// File: tb/tb_adc_spi_frame_capture.sv
// tb_adc_spi_frame_capture: directed scenarios against a behavioural serial ADC model.
module tb_adc_spi_frame_capture;
    logic clk = 1'b0, rst_n = 1'b1, start_cnv = 1'b0, auto_en = 1'b0, m_axis_tready = 1'b1;
    logic [15:0] auto_period = '0;
    logic adc_sclk, adc_cs_n, m_axis_tvalid, m_axis_tlast, busy;
    logic [5:0] adc_sdata = '0;
    logic [95:0] m_axis_tdata;
    logic [7:0] overrun_cnt;
    logic [15:0] adc_word [6];
    int errors = 0, checks = 0, bit_idx = 0, fall_cnt = 0, beat_cnt = 0;
`ifdef ADC_SPI_TSTAMP_EN
    logic [31:0] m_axis_tuser, tb_clk, ts_exp;
    logic prev_cs = 1'b1;
`endif

    always #5 clk = ~clk;

    adc_spi_frame_capture dut (
        .clk(clk), .rst_n(rst_n), .start_cnv(start_cnv), .auto_en(auto_en), .auto_period(auto_period),
        .adc_sclk(adc_sclk), .adc_cs_n(adc_cs_n), .adc_sdata(adc_sdata),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
`ifdef ADC_SPI_TSTAMP_EN
        .m_axis_tuser(m_axis_tuser),
`endif
        .busy(busy), .overrun_cnt(overrun_cnt)
    );

    // ADC shifts the next bit out on each SCLK falling edge: 2 leading zeros, then 12 bits MSB first.
    always @(negedge adc_sclk or posedge adc_cs_n)
        if (adc_cs_n) bit_idx = 0;
        else begin
            for (int c = 0; c < 6; c++) adc_sdata[c] = bit_idx < 2 ? 1'b0 : adc_word[c][13 - bit_idx];
            bit_idx++;
            fall_cnt++;
        end

    always @(negedge clk) begin
        #1;
        if (m_axis_tvalid && m_axis_tready) beat_cnt++;
`ifdef ADC_SPI_TSTAMP_EN
        if (prev_cs && !adc_cs_n) ts_exp = tb_clk;
        prev_cs = adc_cs_n;
`endif
    end

`ifdef ADC_SPI_TSTAMP_EN
    always @(posedge clk or negedge rst_n)
        if (!rst_n) tb_clk <= '0;
        else tb_clk <= tb_clk + 32'd1;
`endif

    task automatic fill(input logic [95:0] v);
        for (int c = 0; c < 6; c++) adc_word[c] = v[c*16 +: 16];
    endtask

    task automatic pulse_start();
        start_cnv = 1'b1;
        repeat (4) @(negedge clk);
        start_cnv = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: busy=%b after %0d clks, expected 0", name, busy, n);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 7;
        if (adc_sclk !== 1'b1) begin errors++; $display("FAIL reset_sclk: got %b expected 1", adc_sclk); end
        if (adc_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b expected 1", adc_cs_n); end
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", m_axis_tvalid); end
        if (m_axis_tdata !== 96'h0) begin errors++; $display("FAIL reset_tdata: got %h expected 0", m_axis_tdata); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL reset_overrun: got %0d expected 0", overrun_cnt); end
        if (m_axis_tlast !== 1'b1) begin errors++; $display("FAIL reset_tlast: got %b expected 1", m_axis_tlast); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_capture();
        int low;
        logic got, last;
        logic [95:0] data;
        low = 0; got = 1'b0; last = 1'b0; data = '0;
        fill(96'h0123_0555_0800_0001_0FFF_0A5C);
        fall_cnt = 0;
        beat_cnt = 0;
        start_cnv = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 3) start_cnv = 1'b0;
            if (!adc_cs_n) low++;
            if (m_axis_tvalid && !got) begin
                got = 1'b1;
                data = m_axis_tdata;
                last = m_axis_tlast;
            end
        end
        #2;
        checks += 6;
        if (got !== 1'b1) begin errors++; $display("FAIL capture_beat_seen: got %b expected 1", got); end
        if (data !== 96'h0123_0555_0800_0001_0FFF_0A5C)
            begin errors++; $display("FAIL capture_tdata: got %h expected 0123_0555_0800_0001_0fff_0a5c", data); end
        if (last !== 1'b1) begin errors++; $display("FAIL capture_tlast: got %b expected 1", last); end
        if (fall_cnt != 14) begin errors++; $display("FAIL capture_sclk_falls: got %0d expected 14", fall_cnt); end
        if (low != 58) begin errors++; $display("FAIL capture_cs_low: got %0d expected 58", low); end
        if (beat_cnt != 1) begin errors++; $display("FAIL capture_beats: got %0d expected 1", beat_cnt); end
`ifdef ADC_SPI_TSTAMP_EN
        checks++;
        if (m_axis_tuser !== ts_exp) begin errors++; $display("FAIL capture_tuser: got %0d expected %0d", m_axis_tuser, ts_exp); end
`endif
    endtask

    task automatic test_auto_period();
        int n, last_fall, n_fall;
        logic prev;
        n = 0; last_fall = 0; n_fall = 0;
        auto_period = 16'd100;
        auto_en = 1'b1;
        while (adc_cs_n && n < 300) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (adc_cs_n !== 1'b0) begin errors++; $display("FAIL auto_first_frame: cs_n=%b after %0d clks, expected 0", adc_cs_n, n); end
        beat_cnt = 0;
        prev = adc_cs_n;
        for (int i = 1; i < 1000; i++) begin
            @(negedge clk);
            if (prev && !adc_cs_n) begin
                n_fall++;
                checks++;
                if (i - last_fall != 100) begin errors++; $display("FAIL auto_interval: got %0d clks expected 100", i - last_fall); end
                last_fall = i;
            end
            prev = adc_cs_n;
        end
        #2;
        checks += 2;
        if (n_fall != 9) begin errors++; $display("FAIL auto_frame_count: got %0d expected 9", n_fall); end
        if (beat_cnt != 10) begin errors++; $display("FAIL auto_beats: got %0d expected 10", beat_cnt); end
        auto_en = 1'b0;
        wait_idle("auto");
    endtask

    task automatic test_back_to_back();
        int n, high, gaps;
        n = 0; high = 0; gaps = 0;
        auto_period = 16'd20;
        auto_en = 1'b1;
        while (adc_cs_n && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (adc_cs_n) high++;
            else begin
                if (high != 0) begin
                    gaps++;
                    checks++;
                    if (high != 2) begin errors++; $display("FAIL b2b_cs_high: got %0d clks expected 2", high); end
                end
                high = 0;
            end
        end
        checks++;
        if (gaps < 4) begin errors++; $display("FAIL b2b_gap_count: got %0d expected at least 4", gaps); end
        auto_en = 1'b0;
        wait_idle("b2b");
    endtask

    task automatic test_backpressure();
`ifdef ADC_SPI_TSTAMP_EN
        logic [31:0] ts1;
`endif
        m_axis_tready = 1'b0;
        fill(96'h0666_0555_0444_0333_0222_0111);
        pulse_start();
        wait_idle("bp1");
`ifdef ADC_SPI_TSTAMP_EN
        ts1 = ts_exp;
`endif
        fill({6{16'h0ABC}});
        pulse_start();
        wait_idle("bp2");
        checks += 3;
        if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL bp2_tvalid: got %b expected 1", m_axis_tvalid); end
        if (m_axis_tdata !== 96'h0666_0555_0444_0333_0222_0111)
            begin errors++; $display("FAIL bp2_tdata: got %h expected 0666_0555_0444_0333_0222_0111", m_axis_tdata); end
        if (overrun_cnt !== 8'd1) begin errors++; $display("FAIL bp2_overrun: got %0d expected 1", overrun_cnt); end
        fill({6{16'h0FFF}});
        pulse_start();
        wait_idle("bp3");
        checks += 3;
        if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL bp3_tvalid: got %b expected 1", m_axis_tvalid); end
        if (m_axis_tdata !== 96'h0666_0555_0444_0333_0222_0111)
            begin errors++; $display("FAIL bp3_tdata: got %h expected 0666_0555_0444_0333_0222_0111", m_axis_tdata); end
        if (overrun_cnt !== 8'd2) begin errors++; $display("FAIL bp3_overrun: got %0d expected 2", overrun_cnt); end
`ifdef ADC_SPI_TSTAMP_EN
        checks++;
        if (m_axis_tuser !== ts1) begin errors++; $display("FAIL bp3_tuser: got %0d expected %0d", m_axis_tuser, ts1); end
`endif
        m_axis_tready = 1'b1;
        @(negedge clk);
        checks += 2;
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL bp_accept_tvalid: got %b expected 0", m_axis_tvalid); end
        if (overrun_cnt !== 8'd2) begin errors++; $display("FAIL bp_accept_overrun: got %0d expected 2", overrun_cnt); end
    endtask

    task automatic test_reset_midframe();
        int n;
        n = 0;
        fill({6{16'h0555}});
        fall_cnt = 0;
        pulse_start();
        while (fall_cnt < 8 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (fall_cnt != 8) begin errors++; $display("FAIL midrst_reach_bit7: got %0d falls expected 8", fall_cnt); end
        #1 rst_n = 1'b0;
        #1;
        checks += 5;
        if (adc_sclk !== 1'b1) begin errors++; $display("FAIL midrst_sclk: got %b expected 1", adc_sclk); end
        if (adc_cs_n !== 1'b1) begin errors++; $display("FAIL midrst_cs_n: got %b expected 1", adc_cs_n); end
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_tvalid: got %b expected 0", m_axis_tvalid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        if (overrun_cnt !== 8'd0) begin errors++; $display("FAIL midrst_overrun: got %0d expected 0", overrun_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        beat_cnt = 0;
        repeat (100) @(negedge clk);
        #2;
        checks += 2;
        if (beat_cnt != 0) begin errors++; $display("FAIL midrst_no_beat: got %0d beats expected 0", beat_cnt); end
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_stay_idle: busy=%b expected 0", busy); end
    endtask

    task automatic test_busy_ignore();
        fill(96'h0FED_0CBA_0987_0654_0321_0ABC);
        beat_cnt = 0;
        pulse_start();
        repeat (16) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy_mid: got %b expected 1", busy); end
        pulse_start();
        wait_idle("ignore");
        repeat (100) @(negedge clk);
        #2;
        checks += 3;
        if (beat_cnt != 1) begin errors++; $display("FAIL ignore_beats: got %0d expected 1", beat_cnt); end
        if (m_axis_tdata !== 96'h0FED_0CBA_0987_0654_0321_0ABC)
            begin errors++; $display("FAIL ignore_tdata: got %h expected 0fed_0cba_0987_0654_0321_0abc", m_axis_tdata); end
        if (busy !== 1'b0) begin errors++; $display("FAIL ignore_no_retrigger: busy=%b expected 0", busy); end
`ifdef ADC_SPI_TSTAMP_EN
        checks++;
        if (m_axis_tuser !== ts_exp) begin errors++; $display("FAIL ignore_tuser: got %0d expected %0d", m_axis_tuser, ts_exp); end
`endif
    endtask

    initial begin
        fill('0);
        test_reset();
        test_capture();
        test_auto_period();
        test_back_to_back();
        test_backpressure();
        test_reset_midframe();
        test_busy_ignore();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
